// File: rtl/ps2_key_decoder_pkg.sv
// Shared constants for the PS/2 keyboard receiver: prefix and ignore-list
// scan codes, frame state encoding and ps2_key field positions.
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_REL = 8'hF0;

  localparam logic [7:0] PS2_BAT_OK  = 8'hAA;
  localparam logic [7:0] PS2_ACK     = 8'hFA;
  localparam logic [7:0] PS2_RESEND  = 8'hFE;
  localparam logic [7:0] PS2_ERR0    = 8'h00;
  localparam logic [7:0] PS2_ERR1    = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam int KEY_CODE_MSB    = 7;
  localparam int KEY_EXT_BIT     = 8;
  localparam int KEY_PRESSED_BIT = 9;
  localparam int KEY_TOGGLE_BIT  = 10;

  // Keyboard housekeeping replies that are dropped unless a prefix is pending
  function automatic logic ps2_is_ignored(input logic [7:0] b);
    return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_RESEND) ||
           (b == PS2_ERR0)   || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Bundle of PS/2 pin inputs and decoded key/status outputs.
interface ps2_key_decoder_if;

  logic        ps2_clk_in;
  logic        ps2_data_in;
  logic [10:0] ps2_key;
  logic        frame_err;
  logic        busy;

  modport master (
    output ps2_clk_in,
    output ps2_data_in,
    input  ps2_key,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  ps2_clk_in,
    input  ps2_data_in,
    output ps2_key,
    output frame_err,
    output busy
  );

endinterface

// File: rtl/ps2_key_decoder_line_filter.sv
// Synchronises the raw PS/2 lines, debounces the clock line and produces a
// one-cycle strobe on each filtered falling edge.
module ps2_line_filter #(
  parameter int FILTER_CYCLES = 8
) (
  input  logic i_clk_sys,
  input  logic i_reset_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_filt_clk,
  output logic o_fall,
  output logic o_data_s
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_data_sync;
  logic [CW-1:0] r_cnt;
  logic          r_filt_clk;
  logic          r_fall;

  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_clk_sync  <= '0;
      r_data_sync <= '0;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
      r_data_sync <= {r_data_sync[0], i_ps2_data};
    end
  end

  // A new level must persist for FILTER_CYCLES samples; any agreeing sample restarts the count
  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt      <= '0;
      r_filt_clk <= 1'b0;
      r_fall     <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (r_clk_sync[1] == r_filt_clk) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_CYCLES - 1)) begin
        r_cnt      <= '0;
        r_filt_clk <= r_clk_sync[1];
        r_fall     <= ~r_clk_sync[1];
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_filt_clk = r_filt_clk;
  assign o_fall     = r_fall;
  assign o_data_s   = r_data_sync[1];

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: frames bits into bytes, handles E0/F0 prefixes and
// emits the 11-bit ps2_key event word with a per-event toggle bit.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 48000
) (
  input logic              clk_sys,
  input logic              reset_n,
  ps2_key_decoder_if.slave bus
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_DATA   = DATA;
  localparam logic [1:0] S_PARITY = PARITY;
  localparam logic [1:0] S_STOP   = STOP;
  localparam int         TW       = $clog2(TIMEOUT_CYCLES);

  logic          w_filt_clk;
  logic          w_fall_raw;
  logic          w_fall;
  logic          w_data_s;
  logic          w_timeout;
  logic          w_stop_fall;
  logic          w_frame_ok;
  logic [1:0]    w_state_nxt;

  logic [1:0]    r_state;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shreg;
  logic          r_parity;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_ext;
  logic          r_rel;
  logic [10:0]   r_key;
  logic          r_frame_err;
  logic          r_busy;

  ps2_line_filter #(
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_line_filter (
    .i_clk_sys  (clk_sys),
    .i_reset_n  (reset_n),
    .i_ps2_clk  (bus.ps2_clk_in),
    .i_ps2_data (bus.ps2_data_in),
    .o_filt_clk (w_filt_clk),
    .o_fall     (w_fall_raw),
    .o_data_s   (w_data_s)
  );

  assign w_fall      = w_fall_raw & ~w_filt_clk;
  assign w_timeout   = (r_state != S_IDLE) && !w_fall &&
                       (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_stop_fall = w_fall && (r_state == S_STOP);
  assign w_frame_ok  = w_data_s && (^{r_shreg, r_parity});

  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE:   w_state_nxt = w_data_s ? S_IDLE : S_DATA;
        S_DATA:   w_state_nxt = (r_bit_idx == 3'd7) ? S_PARITY : S_DATA;
        S_PARITY: w_state_nxt = S_STOP;
        S_STOP:   w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_bit_idx <= '0;
      r_shreg   <= '0;
      r_parity  <= 1'b0;
      r_tmo_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      if ((r_state == S_IDLE) || w_fall) begin
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + TW'(1);
      end
      if (w_fall) begin
        case (r_state)
          S_IDLE:   r_bit_idx <= '0;
          S_DATA: begin
            r_shreg   <= {w_data_s, r_shreg[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
          end
          S_PARITY: r_parity <= w_data_s;
          default:  ;
        endcase
      end
    end
  end

  // Bad frames and timeouts also drop any half-received prefix sequence
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_key       <= '0;
      r_ext       <= 1'b0;
      r_rel       <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_timeout || (w_stop_fall && !w_frame_ok);
      if (w_timeout || (w_stop_fall && !w_frame_ok)) begin
        r_ext <= 1'b0;
        r_rel <= 1'b0;
      end else if (w_stop_fall) begin
        if (r_shreg == PS2_PFX_EXT) begin
          r_ext <= 1'b1;
        end else if (r_shreg == PS2_PFX_REL) begin
          r_rel <= 1'b1;
        end else if (!(ps2_is_ignored(r_shreg) && !r_ext && !r_rel)) begin
          r_key[KEY_TOGGLE_BIT]   <= ~r_key[KEY_TOGGLE_BIT];
          r_key[KEY_PRESSED_BIT]  <= ~r_rel;
          r_key[KEY_EXT_BIT]      <= r_ext;
          r_key[KEY_CODE_MSB:0]   <= r_shreg;
          r_ext <= 1'b0;
          r_rel <= 1'b0;
        end
      end
    end
  end

  assign bus.ps2_key   = r_key;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = r_busy;

endmodule
